// File: rtl/rv_mem_pkg.sv
// Shared load/store encodings and MEM-stage FSM states for the RV32I memory stage.
package rv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory: store lane shift and byte enables,
// load lane extract with sign/zero extension, and misalignment detection.
module lsu_align
  import rv_mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic        is_mem,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  bweb,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Misalignment is judged on the size bits only, so it applies to loads and stores alike
  always_comb begin
    misalign = 1'b0;
    if (is_mem) begin
      case (funct3[1:0])
        2'b01:   misalign = addr[0];
        2'b10:   misalign = (addr != 2'b00);
        default: misalign = 1'b0;
      endcase
    end else begin
      misalign = 1'b0;
    end
  end

  // Store data is replicated across lanes; the active-low enables pick the lane
  always_comb begin
    wdata = store_data;
    bweb  = 4'hF;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wdata = {4{store_data[7:0]}};
          bweb  = ~(4'b0001 << addr);
        end
        F3_SH: begin
          wdata = {2{store_data[15:0]}};
          bweb  = addr[1] ? 4'b0011 : 4'b1100;
        end
        F3_SW: begin
          wdata = store_data;
          bweb  = 4'b0000;
        end
        default: begin
          wdata = store_data;
          bweb  = 4'hF;
        end
      endcase
    end else begin
      wdata = store_data;
      bweb  = 4'hF;
    end
  end

  // Load lane extract followed by sign or zero extension
  always_comb begin
    byte_shift = rdata >> {addr, 3'b000};
    half_shift = rdata >> {addr[1], 4'b0000};
    byte_v     = byte_shift[7:0];
    half_v     = half_shift[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  load_data = {24'h000000, byte_v};
      F3_LH:   load_data = {{16{half_v[15]}}, half_v};
      F3_LHU:  load_data = {16'h0000, half_v};
      F3_LW:   load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// RV32I memory stage with ready-handshake data port, stall generation,
// and the MEM/WB pipeline register feeding write-back and forwarding.
module mem_wb_stage
  import rv_mem_pkg::*;
#(
  parameter int DM_AW = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      alu_out_mem,
  input  logic [31:0]      store_data_mem,
  input  logic [4:0]       rd_addr_mem,
  input  logic             wb_en_mem,
  input  logic             mem_rd_mem,
  input  logic             mem_wr_mem,
  input  logic [2:0]       funct3_mem,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [3:0]       dm_bweb,
  output logic [31:0]      dm_wdata,
  input  logic             dm_ready,
  input  logic [31:0]      dm_rdata,
  output logic             stall_mem,
  output logic [31:0]      fw_from_mem,
  output logic [31:0]      fw_from_wb,
  output logic [31:0]      wb_data_wb,
  output logic [4:0]       rd_addr_wb,
  output logic             wb_en_wb,
  output logic             misalign_wb
);

  mem_state_t  state;
  logic        mem_op;
  logic        is_load;
  logic        misalign;
  logic        req;
  logic [31:0] load_data;

  assign mem_op  = mem_rd_mem | mem_wr_mem;
  assign is_load = mem_rd_mem & ~mem_wr_mem;

  lsu_align u_align (
    .addr       (alu_out_mem[1:0]),
    .funct3     (funct3_mem),
    .is_mem     (mem_op),
    .is_store   (mem_wr_mem),
    .store_data (store_data_mem),
    .rdata      (dm_rdata),
    .wdata      (dm_wdata),
    .bweb       (dm_bweb),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  // Gating with rst drops the request the instant reset asserts, even mid-access
  assign req         = rst & ((state == WAIT) | (mem_op & ~misalign));
  assign dm_req      = req;
  assign dm_we       = req & mem_wr_mem;
  assign dm_addr     = alu_out_mem[DM_AW+1:2];
  assign stall_mem   = req & ~dm_ready;
  assign fw_from_mem = alu_out_mem;
  assign fw_from_wb  = wb_data_wb;

  // Access FSM: leave IDLE only when the memory does not accept on the first cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= stall_mem ? WAIT : IDLE;
        WAIT:    state <= dm_ready ? IDLE : WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register; a stalled cycle inserts a bubble so each instruction writes once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_wb  <= 32'h0000_0000;
      rd_addr_wb  <= 5'd0;
      wb_en_wb    <= 1'b0;
      misalign_wb <= 1'b0;
    end else if (stall_mem) begin
      wb_en_wb    <= 1'b0;
      misalign_wb <= 1'b0;
    end else begin
      rd_addr_wb  <= rd_addr_mem;
      wb_en_wb    <= wb_en_mem & (rd_addr_mem != 5'd0) & ~misalign;
      wb_data_wb  <= is_load ? load_data : alu_out_mem;
      misalign_wb <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_mem, store_data_mem, dm_rdata;
  logic [4:0]  rd_addr_mem;
  logic        wb_en_mem, mem_rd_mem, mem_wr_mem, dm_ready;
  logic [2:0]  funct3_mem;
  logic        dm_req, dm_we, stall_mem, wb_en_wb, misalign_wb;
  logic [13:0] dm_addr;
  logic [3:0]  dm_bweb;
  logic [31:0] dm_wdata, fw_from_mem, fw_from_wb, wb_data_wb;
  logic [4:0]  rd_addr_wb;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(.DM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .alu_out_mem(alu_out_mem), .store_data_mem(store_data_mem),
    .rd_addr_mem(rd_addr_mem), .wb_en_mem(wb_en_mem),
    .mem_rd_mem(mem_rd_mem), .mem_wr_mem(mem_wr_mem), .funct3_mem(funct3_mem),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_bweb(dm_bweb),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .stall_mem(stall_mem), .fw_from_mem(fw_from_mem), .fw_from_wb(fw_from_wb),
    .wb_data_wb(wb_data_wb), .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb),
    .misalign_wb(misalign_wb)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic wen, input logic mrd, input logic mwr, input logic [2:0] f3,
                       input logic rdy, input logic [31:0] rdat);
    alu_out_mem = alu; store_data_mem = sd; rd_addr_mem = rd; wb_en_mem = wen;
    mem_rd_mem = mrd; mem_wr_mem = mwr; funct3_mem = f3; dm_ready = rdy; dm_rdata = rdat;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    #12;
    n_checks++;
    if ({dm_req, stall_mem, wb_en_wb, misalign_wb} !== 4'b0000 || wb_data_wb !== 32'h0 || rd_addr_wb !== 5'd0) begin
      n_fail++;
      $display("FAIL reset: req=%b stall=%b en=%b mis=%b data=%h rd=%0d, expected all zero",
               dm_req, stall_mem, wb_en_wb, misalign_wb, wb_data_wb, rd_addr_wb);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store();
    @(negedge clk);
    drive(32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, F3_SW, 1'b1, 32'h0);
    #1;
    n_checks++;
    if ({dm_req, dm_we, stall_mem} !== 3'b110 || dm_addr !== 14'h40 || dm_bweb !== 4'b0000 || dm_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_port: req=%b we=%b stall=%b addr=%h bweb=%b wdata=%h, expected 1 1 0 0040 0000 deadbeef",
               dm_req, dm_we, stall_mem, dm_addr, dm_bweb, dm_wdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if (wb_en_wb !== 1'b0 || misalign_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_wb: en=%b mis=%b, expected 0 0", wb_en_wb, misalign_wb);
    end
    @(negedge clk);
    drive(32'h102, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, F3_SB, 1'b1, 32'h0);
    #1;
    n_checks++;
    if (dm_bweb !== 4'b1011 || dm_wdata !== 32'hABAB_ABAB) begin
      n_fail++;
      $display("FAIL sb_lane: bweb=%b wdata=%h, expected 1011 abababab", dm_bweb, dm_wdata);
    end
    @(negedge clk);
    drive(32'h102, 32'h0000_5A5A, 5'd0, 1'b0, 1'b0, 1'b1, F3_SH, 1'b1, 32'h0);
    #1;
    n_checks++;
    if (dm_bweb !== 4'b0011 || dm_wdata !== 32'h5A5A_5A5A || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_lane: bweb=%b wdata=%h stall=%b, expected 0011 5a5a5a5a 0", dm_bweb, dm_wdata, stall_mem);
    end
    // rd and wr together: store wins, write-back data is the ALU result
    @(negedge clk);
    drive(32'h204, 32'h1111_2222, 5'd3, 1'b1, 1'b1, 1'b1, F3_SW, 1'b1, 32'h9999_9999);
    #1;
    n_checks++;
    if (dm_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rdwr_we: we=%b, expected 1", dm_we);
    end
    @(posedge clk); #1;
    n_checks++;
    if (wb_data_wb !== 32'h0000_0204) begin
      n_fail++;
      $display("FAIL rdwr_data: data=%h, expected 00000204", wb_data_wb);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [31:0] addrs[4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(addrs[i], 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, f3s[i], 1'b1, 32'h80FF_FF12);
      @(posedge clk); #1;
      n_checks++;
      if (wb_data_wb !== exps[i] || rd_addr_wb !== 5'd5 || wb_en_wb !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: data=%h rd=%0d en=%b, expected %h 5 1", i, wb_data_wb, rd_addr_wb, wb_en_wb, exps[i]);
      end
    end
  endtask

  task automatic test_wait_stall();
    int stalls = 0;
    @(negedge clk);
    drive(32'h200, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, F3_LW, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (stall_mem === 1'b1) stalls++;
      n_checks++;
      if (dm_req !== 1'b1 || dm_addr !== 14'h80 || dm_bweb !== 4'hF || dm_we !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h bweb=%b we=%b, expected 1 0080 1111 0", c, dm_req, dm_addr, dm_bweb, dm_we);
      end
      @(posedge clk); #1;
      n_checks++;
      if (wb_en_wb !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_bubble[%0d]: en=%b, expected 0", c, wb_en_wb);
      end
      @(negedge clk);
    end
    dm_ready = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    #1;
    if (stall_mem === 1'b1) stalls++;
    n_checks++;
    if (stalls !== 3) begin
      n_fail++;
      $display("FAIL wait_count: stall cycles=%0d, expected 3", stalls);
    end
    @(posedge clk); #1;
    n_checks++;
    if (wb_en_wb !== 1'b1 || wb_data_wb !== 32'hCAFE_F00D || rd_addr_wb !== 5'd8) begin
      n_fail++;
      $display("FAIL wait_wb: en=%b data=%h rd=%0d, expected 1 cafef00d 8", wb_en_wb, wb_data_wb, rd_addr_wb);
    end
    @(negedge clk);
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (wb_en_wb !== 1'b0 || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_once: en=%b stall=%b, expected 0 0", wb_en_wb, stall_mem);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive(32'h101, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, F3_LH, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (dm_req !== 1'b0 || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_noreq: req=%b stall=%b, expected 0 0", dm_req, stall_mem);
    end
    @(posedge clk); #1;
    n_checks++;
    if (misalign_wb !== 1'b1 || wb_en_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_flag: mis=%b en=%b, expected 1 0", misalign_wb, wb_en_wb);
    end
    @(negedge clk);
    drive(32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (misalign_wb !== 1'b0 || wb_en_wb !== 1'b0 || wb_data_wb !== 32'h55) begin
      n_fail++;
      $display("FAIL rd_zero: mis=%b en=%b data=%h, expected 0 0 00000055", misalign_wb, wb_en_wb, wb_data_wb);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive(32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (fw_from_mem !== 32'h1234 || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL fw_mem: fw=%h stall=%b, expected 00001234 0", fw_from_mem, stall_mem);
    end
    @(posedge clk); #1;
    n_checks++;
    if (fw_from_wb !== 32'h1234 || wb_en_wb !== 1'b1 || rd_addr_wb !== 5'd7) begin
      n_fail++;
      $display("FAIL fw_wb: fw=%h en=%b rd=%0d, expected 00001234 1 7", fw_from_wb, wb_en_wb, rd_addr_wb);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, F3_LW, 1'b0, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (dm_req !== 1'b0 || stall_mem !== 1'b0 || wb_en_wb !== 1'b0 || wb_data_wb !== 32'h0 || rd_addr_wb !== 5'd0 || misalign_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait: req=%b stall=%b en=%b data=%h rd=%0d mis=%b, expected all zero",
               dm_req, stall_mem, wb_en_wb, wb_data_wb, rd_addr_wb, misalign_wb);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(32'h304, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_LW, 1'b1, 32'h1122_3344);
    #1;
    n_checks++;
    if (dm_req !== 1'b1 || stall_mem !== 1'b0 || dm_addr !== 14'hC1) begin
      n_fail++;
      $display("FAIL rst_after_req: req=%b stall=%b addr=%h, expected 1 0 00c1", dm_req, stall_mem, dm_addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (wb_data_wb !== 32'h1122_3344 || wb_en_wb !== 1'b1 || rd_addr_wb !== 5'd9) begin
      n_fail++;
      $display("FAIL rst_after_wb: data=%h en=%b rd=%0d, expected 11223344 1 9", wb_data_wb, wb_en_wb, rd_addr_wb);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_extend();
    test_wait_stall();
    test_misalign();
    test_forward();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage RV32I core.
- Sits directly downstream of the EX/MEM register and consumes its result, store data, rd address, write-enable and memory-op controls.
- Performs load/store through a ready-handshake data-memory port and stalls the pipeline while the access is outstanding.
- Registers write-back data and produces both forwarding sources back to the EX stage: fw_from_mem and fw_from_wb.

Parameters:
DM_AW, 14, data-memory word-address width; byte address bits [DM_AW+1:2] select the word.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
alu_out_mem  in  32  EX/MEM result; byte address for loads and stores
store_data_mem  in  32  EX/MEM rs2 value for stores
rd_addr_mem  in  5  destination register
wb_en_mem  in  1  register write-back request
mem_rd_mem  in  1  load instruction in MEM
mem_wr_mem  in  1  store instruction in MEM
funct3_mem  in  3  load/store size and sign
dm_req  out  1  memory request, held until accepted
dm_we  out  1  1 = write
dm_addr  out  DM_AW  word address
dm_bweb  out  4  byte write-enable, active-low; 4'hF on reads
dm_wdata  out  32  lane-shifted store data
dm_ready  in  1  request accepted; read data valid this cycle
dm_rdata  in  32  read word
stall_mem  out  1  hold IF..EX/MEM registers
fw_from_mem  out  32  equals alu_out_mem (combinational)
fw_from_wb  out  32  equals wb_data_wb
wb_data_wb  out  32  registered write-back data
rd_addr_wb  out  5  registered rd
wb_en_wb  out  1  registered write enable
misalign_wb  out  1  one-cycle registered flag for a misaligned access

Behaviour:
- Reset while rst=0, asynchronous:
  - state=IDLE.
  - wb_data_wb=0, rd_addr_wb=0, wb_en_wb=0, misalign_wb=0.
  - dm_req=0 immediately; reset mid-access abandons the request.
- mem op = mem_rd_mem | mem_wr_mem. If both are high, the access is a store and the read is ignored.
- Misaligned access:
  - Condition: word access with addr[1:0]!=0, or halfword access with addr[0]!=0.
  - No dm_req is issued and there is no stall.
  - Next edge: misalign_wb=1 and wb_en_wb=0.
- FSM IDLE / WAIT:
  - IDLE, aligned mem op: dm_req=1 combinationally.
    - If dm_ready=1: the access completes this cycle with zero wait and state stays IDLE.
    - Otherwise: stall_mem=1 and the next state is WAIT.
  - IDLE, non-mem op: no request, stall_mem=0, and the instruction passes to WB on the next edge.
  - WAIT: dm_req, dm_we, dm_addr, dm_bweb and dm_wdata are held at their IDLE-cycle values (upstream is frozen).
    - stall_mem=1 until dm_ready.
    - The cycle dm_ready=1: stall_mem=0, the access completes, and the next state is IDLE.
- MEM/WB register update every edge:
  - Completing or non-mem cycle:
    - rd_addr_wb <= rd_addr_mem.
    - wb_en_wb <= wb_en_mem & (rd_addr_mem!=0) & ~misalign.
    - wb_data_wb <= load ? extended read data : alu_out_mem.
  - Stalled cycle: wb_en_wb <= 0 (bubble), so each instruction writes back exactly once.
- Load extension on dm_rdata, lane selected by addr[1:0]:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store:
  - SB: data byte replicated to all lanes, bweb lane = 0 at addr[1:0].
  - SH: halfword replicated, bweb = 4'b1100 or 4'b0011.
  - SW: bweb = 4'b0000.
- Latency: zero-wait memory gives 1 cycle MEM→WB, no stall. N wait cycles give N stall cycles.
- fw_from_mem is valid for non-load instructions only; the load-use hazard is owned by the hazard unit.

Decomposition:
- Package rv_mem_pkg:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - mem_state_t enum {IDLE, WAIT}.
- One combinational sub-module, lsu_align: store lane shift plus bweb, load extract plus extend, and misalign detection.

Test Plan:
- SW to 0x100, data 0xDEADBEEF, dm_ready=1 the same cycle → dm_addr=0x40, dm_bweb=4'b0000, dm_we=1, stall_mem never asserted, wb_en_wb=0 next edge.
- LB from 0x103, dm_rdata=0x80FF_FF12, rd=5 → wb_data_wb=0xFFFF_FF80, rd_addr_wb=5, wb_en_wb=1. Same access as LBU → 0x0000_0080.
- LW with dm_ready low for 3 cycles → stall_mem=1 for exactly 3 cycles, wb_en_wb=0 during the stall, then a single write-back of dm_rdata.
- LH at 0x101 → no dm_req, misalign_wb=1 for one cycle, wb_en_wb=0. ADD with rd=0 → wb_en_wb=0 but wb_data_wb still updated.
- rst driven low during WAIT → dm_req falls asynchronously, state=IDLE, all outputs 0. After release, the next load completes normally.
- Non-mem ADD result 0x1234, rd=7 → fw_from_mem=0x1234 same cycle; fw_from_wb=0x1234 and wb_en_wb=1 after one edge.
